// File: rtl/fft_pkg.sv
// fft_pkg: shared Q16.16 constants, butterfly state enum and complex sample type
package fft_pkg;
  localparam int Q_W = 32;
  localparam int Q_FRAC = 16;
  localparam logic [Q_W-1:0] ONE_Q16 = 32'h00010000;
  typedef enum logic [2:0] {IDLE, HALF, CALC, OUT_A, OUT_B} state_t;
  typedef struct packed {
    logic [Q_W-1:0] re;
    logic [Q_W-1:0] im;
  } complex_q16;
endpackage

// File: rtl/cmul_conj_q16.sv
// cmul_conj_q16: combinational d*conj(w) for a 33-bit difference and Q16.16 twiddle, floor-truncated to Q16.16
module cmul_conj_q16
  import fft_pkg::*;
(
  input  logic signed [Q_W:0]   d_re,
  input  logic signed [Q_W:0]   d_im,
  input  logic        [Q_W-1:0] w_re,
  input  logic        [Q_W-1:0] w_im,
  output complex_q16            y
);
  localparam int PW = Q_W + Q_FRAC;
  logic signed [PW-1:0] wr, wi, p_re, p_im;
  logic [Q_FRAC-1:0] unused_re, unused_im;
  assign wr = PW'($signed(w_re));
  assign wi = PW'($signed(w_im));
  // only bits [47:0] of the products survive truncation, so 48-bit arithmetic is exact here
  assign p_re = PW'(d_re) * wr + PW'(d_im) * wi;
  assign p_im = PW'(d_im) * wr - PW'(d_re) * wi;
  assign {y.re, unused_re} = p_re;
  assign {y.im, unused_im} = p_im;
endmodule

// File: rtl/ifft_butterfly_2_point_seq.sv
// ifft_butterfly_2_point_seq: serial 2-point inverse butterfly a=x0+x1, b=(x0-x1)*conj(W); IFFT_SCALE_EN halves both results
module ifft_butterfly_2_point_seq
  import fft_pkg::*;
#(
  parameter logic [Q_W-1:0] W_REAL = ONE_Q16,
  parameter logic [Q_W-1:0] W_IMAG = 32'h00000000
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           in_first,
  input  logic [Q_W-1:0] in_real,
  input  logic [Q_W-1:0] in_imag,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [Q_W-1:0] out_real,
  output logic [Q_W-1:0] out_imag,
  output logic           out_index,
  output logic [15:0]    drop_cnt
);
  localparam int SW = Q_W + 1;
  state_t state_q, state_d;
  complex_q16 x0_q, x0_d, x1_q, x1_d, a_q, a_d, b_q, b_d, out_q, out_d;
  complex_q16 a_calc, b_calc, prod;
  logic live_q, out_valid_q, out_valid_d, out_index_q, out_index_d;
  logic [15:0] drop_q, drop_d;
  logic in_fire, out_fire;
  logic signed [SW-1:0] s_re, s_im, d_re, d_im;
  assign in_ready = live_q && (state_q == IDLE || state_q == HALF);
  assign in_fire = in_valid && in_ready;
  assign out_fire = out_valid_q && out_ready;
  assign out_valid = out_valid_q;
  assign out_index = out_index_q;
  assign out_real = out_q.re;
  assign out_imag = out_q.im;
  assign drop_cnt = drop_q;
  assign s_re = SW'($signed(x0_q.re)) + SW'($signed(x1_q.re));
  assign s_im = SW'($signed(x0_q.im)) + SW'($signed(x1_q.im));
  assign d_re = SW'($signed(x0_q.re)) - SW'($signed(x1_q.re));
  assign d_im = SW'($signed(x0_q.im)) - SW'($signed(x1_q.im));
  cmul_conj_q16 u_cmul (
    .d_re(d_re),
    .d_im(d_im),
    .w_re(W_REAL),
    .w_im(W_IMAG),
    .y   (prod)
  );
`ifdef IFFT_SCALE_EN
  logic [3:0] unused_lsb;
  assign unused_lsb = {s_re[0], s_im[0], prod.re[0], prod.im[0]};
  assign a_calc = '{re: s_re[Q_W:1], im: s_im[Q_W:1]};
  assign b_calc = '{re: {prod.re[Q_W-1], prod.re[Q_W-1:1]}, im: {prod.im[Q_W-1], prod.im[Q_W-1:1]}};
`else
  logic [1:0] unused_msb;
  assign unused_msb = {s_re[Q_W], s_im[Q_W]};
  assign a_calc = '{re: s_re[Q_W-1:0], im: s_im[Q_W-1:0]};
  assign b_calc = prod;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      live_q <= 1'b0;
      x0_q <= '0;
      x1_q <= '0;
      a_q <= '0;
      b_q <= '0;
      out_q <= '0;
      out_valid_q <= 1'b0;
      out_index_q <= 1'b0;
      drop_q <= '0;
    end else begin
      state_q <= state_d;
      live_q <= 1'b1;
      x0_q <= x0_d;
      x1_q <= x1_d;
      a_q <= a_d;
      b_q <= b_d;
      out_q <= out_d;
      out_valid_q <= out_valid_d;
      out_index_q <= out_index_d;
      drop_q <= drop_d;
    end
  end
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_fire && in_first) state_d = HALF;
      HALF:    if (in_fire && !in_first) state_d = CALC;
      CALC:    state_d = OUT_A;
      OUT_A:   if (out_fire) state_d = OUT_B;
      OUT_B:   if (out_fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // OUT_A spends its first cycle loading a into the output register, so a appears two edges after x1
  always_comb begin
    x0_d = (in_fire && in_first) ? complex_q16'({in_real, in_imag}) : x0_q;
    x1_d = (in_fire && !in_first && state_q == HALF) ? complex_q16'({in_real, in_imag}) : x1_q;
    drop_d = (in_fire && in_first && state_q == HALF && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
    a_d = (state_q == CALC) ? a_calc : a_q;
    b_d = (state_q == CALC) ? b_calc : b_q;
    out_valid_d = (state_q == OUT_A) || (state_q == OUT_B && !out_ready);
    out_d = (state_q == OUT_A && !out_valid_q) ? a_q :
            (state_q == OUT_A && out_fire) ? b_q :
            (state_q == OUT_B && out_fire) ? '0 : out_q;
    out_index_d = (state_q == OUT_A && out_fire) ? 1'b1 :
                  (state_q == OUT_B && out_fire) ? 1'b0 : out_index_q;
  end
endmodule

// File: tb/tb_ifft_butterfly_2_point_seq.sv
// tb_ifft_butterfly_2_point_seq: vector table + scoreboard bench over default-W and W=j instances
module tb_ifft_butterfly_2_point_seq;
  logic clk = 1'b0;
  logic rst, in_valid, in_first, out_ready;
  logic [31:0] in_real, in_imag;
  logic in_ready0, in_ready1, out_valid0, out_valid1, out_index0, out_index1;
  logic [31:0] ore0, oim0, ore1, oim1;
  logic [15:0] drop0, drop1;
  always #5 clk = ~clk;
  ifft_butterfly_2_point_seq dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .in_first(in_first),
    .in_real(in_real), .in_imag(in_imag), .out_valid(out_valid0), .out_ready(out_ready),
    .out_real(ore0), .out_imag(oim0), .out_index(out_index0), .drop_cnt(drop0)
  );
  ifft_butterfly_2_point_seq #(.W_REAL(32'h00000000), .W_IMAG(32'h00010000)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .in_first(in_first),
    .in_real(in_real), .in_imag(in_imag), .out_valid(out_valid1), .out_ready(out_ready),
    .out_real(ore1), .out_imag(oim1), .out_index(out_index1), .drop_cnt(drop1)
  );
  typedef struct {
    logic [31:0] re, im;
    logic idx;
  } exp_t;
  // a given both unscaled (32-bit wrap) and scaled (33-bit sum halved); b given unscaled
  typedef struct {
    logic [31:0] x0r, x0i, x1r, x1i, ar_n, ai_n, ar_s, ai_s, b1r, b1i, b2r, b2i;
  } vec_t;
  exp_t q0[$], q1[$];
  exp_t e0, e1;
  vec_t vecs[5];
  vec_t rs;
  int n_chk = 0, n_fail = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic [31:0] sh(input logic [31:0] v);
`ifdef IFFT_SCALE_EN
    return {v[31], v[31:1]};
`else
    return v;
`endif
  endfunction
  function automatic logic [63:0] a_of(input vec_t v);
`ifdef IFFT_SCALE_EN
    return {v.ar_s, v.ai_s};
`else
    return {v.ar_n, v.ai_n};
`endif
  endfunction
  task automatic push(input vec_t v);
    logic [63:0] a;
    a = a_of(v);
    q0.push_back('{a[63:32], a[31:0], 1'b0});
    q0.push_back('{sh(v.b1r), sh(v.b1i), 1'b1});
    q1.push_back('{a[63:32], a[31:0], 1'b0});
    q1.push_back('{sh(v.b2r), sh(v.b2i), 1'b1});
  endtask
  task automatic send(input logic f, input logic [31:0] r, input logic [31:0] i);
    logic ok;
    int n;
    n = 0;
    in_valid = 1'b1;
    in_first = f;
    in_real = r;
    in_imag = i;
    do begin
      @(negedge clk);
      ok = in_ready0 && in_ready1;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 50);
    in_valid = 1'b0;
    check("send_accepted", {31'b0, ok}, 32'd1);
  endtask
  task automatic send_pair(input vec_t v);
    send(1'b1, v.x0r, v.x0i);
    send(1'b0, v.x1r, v.x1i);
  endtask
  task automatic wait_empty();
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_timeout", n, (n < 100) ? n : 32'hFFFFFFFF);
  endtask
  task automatic wait_valid();
    int n;
    n = 0;
    while (!out_valid0 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("out_valid_wait", {31'b0, out_valid0}, 32'd1);
  endtask
  always @(negedge clk) begin
    if (!rst && out_ready) begin
      if (out_valid0) begin
        if (q0.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL dut0_unexpected: got %h/%h idx %0d expected nothing", ore0, oim0, out_index0);
        end else begin
          e0 = q0.pop_front();
          check("dut0_re", ore0, e0.re);
          check("dut0_im", oim0, e0.im);
          check("dut0_idx", {31'b0, out_index0}, {31'b0, e0.idx});
        end
      end
      if (out_valid1) begin
        if (q1.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL dut1_unexpected: got %h/%h idx %0d expected nothing", ore1, oim1, out_index1);
        end else begin
          e1 = q1.pop_front();
          check("dut1_re", ore1, e1.re);
          check("dut1_im", oim1, e1.im);
          check("dut1_idx", {31'b0, out_index1}, {31'b0, e1.idx});
        end
      end
    end
  end
  initial begin
    logic [63:0] a;
    logic [15:0] d;
    vecs[0] = '{32'h00010000, 0, 32'h00008000, 0, 32'h00018000, 0, 32'h0000C000, 0,
                32'h00008000, 0, 0, 32'hFFFF8000};
    vecs[1] = '{32'h7FFF0000, 0, 32'h00010000, 0, 32'h80000000, 0, 32'h40000000, 0,
                32'h7FFE0000, 0, 0, 32'h80020000};
    vecs[2] = '{32'h00030000, 32'h00020000, 32'h00010000, 32'h00050000, 32'h00040000, 32'h00070000,
                32'h00020000, 32'h00038000, 32'h00020000, 32'hFFFD0000, 32'hFFFD0000, 32'hFFFE0000};
    vecs[3] = '{32'hFFFF0000, 0, 32'hFFFF0000, 32'h00008000, 32'hFFFE0000, 32'h00008000,
                32'hFFFF0000, 32'h00004000, 0, 32'hFFFF8000, 32'hFFFF8000, 0};
    vecs[4] = '{32'h00000001, 0, 0, 0, 32'h00000001, 0, 0, 0, 32'h00000001, 0, 0, 32'hFFFFFFFF};
    rs = '{32'h00020000, 0, 0, 0, 32'h00020000, 0, 32'h00010000, 0, 32'h00020000, 0, 0, 32'hFFFE0000};
    rst = 1'b1;
    in_valid = 1'b0;
    in_first = 1'b0;
    in_real = '0;
    in_imag = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {31'b0, in_ready0}, 0);
    check("rst_out_valid", {31'b0, out_valid0}, 0);
    check("rst_out_real", ore0, 0);
    check("rst_out_imag", oim0, 0);
    check("rst_out_index", {31'b0, out_index0}, 0);
    check("rst_drop_cnt", {16'b0, drop0}, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", {31'b0, in_ready0}, 1);
    push(vecs[0]);
    send_pair(vecs[0]);
    @(posedge clk);
    #1;
    check("lat_not_yet", {31'b0, out_valid0}, 0);
    check("lat_in_ready_low", {31'b0, in_ready0}, 0);
    @(posedge clk);
    #1;
    check("lat_valid", {31'b0, out_valid0}, 1);
    wait_empty();
    for (int k = 1; k < 5; k++) begin
      push(vecs[k]);
      send_pair(vecs[k]);
      wait_empty();
    end
    d = drop0;
    send(1'b0, 32'h12340000, 0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("idle_discard_valid", {31'b0, out_valid0}, 0);
    check("idle_discard_drop", {16'b0, drop0}, {16'b0, d});
    push(rs);
    send(1'b1, 32'h00010000, 0);
    send(1'b1, 32'h00020000, 0);
    send(1'b0, 0, 0);
    check("resync_drop", {16'b0, drop0}, {16'b0, d} + 1);
    wait_empty();
    out_ready = 1'b0;
    a = a_of(vecs[0]);
    push(vecs[0]);
    send_pair(vecs[0]);
    wait_valid();
    repeat (5) begin
      @(posedge clk);
      #1;
      check("bp_valid", {31'b0, out_valid0}, 1);
      check("bp_real", ore0, a[63:32]);
      check("bp_idx", {31'b0, out_index0}, 0);
      check("bp_in_ready", {31'b0, in_ready0}, 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("bp_b_valid", {31'b0, out_valid0}, 1);
    check("bp_b_idx", {31'b0, out_index0}, 1);
    @(posedge clk);
    #1;
    check("bp_b_hold", {31'b0, out_index0 & out_valid0}, 1);
    check("bp_b_real", ore0, sh(vecs[0].b1r));
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("bp_done_valid", {31'b0, out_valid0}, 0);
    check("bp_done_queue", q0.size(), 0);
    check("bp_idle_in_ready", {31'b0, in_ready0}, 1);
    push(vecs[1]);
    send_pair(vecs[1]);
    wait_valid();
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_valid", {31'b0, out_valid0}, 0);
    check("mid_rst_drop", {16'b0, drop0}, 0);
    check("mid_rst_in_ready", {31'b0, in_ready0}, 0);
    check("mid_rst_real", ore0, 0);
    q0.delete();
    q1.delete();
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_in_ready_up", {31'b0, in_ready0}, 1);
    repeat (5) begin
      @(posedge clk);
      #1;
      check("no_stale_out", {30'b0, out_valid0, out_valid1}, 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
